// File: rtl/hex_segment_decoder.sv
// Decodes a stable pair of active-low 7-segment digits (0..31) back to binary over valid/ready.
// Define SEG_ERR_COUNT_EN to add the saturating err_count port and counter.
module hex_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       hex1,
  input  logic [6:0]       hex0,
  output logic [4:0]       value,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             pattern_err,
  input  logic             err_clr
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [ERR_W-1:0] err_count
`endif
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [13:0]    Idle   = 14'h3fff;

  logic [13:0]     pat;
  logic [13:0]     sample_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            same, eval, is_idle;

  logic            ones_ok, tens_ok, legal, capture, illegal;
  logic [3:0]      ones_val;
  logic [1:0]      tens_val;
  logic [5:0]      sum;

  logic [4:0]      value_q, value_d;
  logic            valid_q, valid_d;
  logic [4:0]      last_q, last_d;
  logic            last_vld_q, last_vld_d;
  logic            err_q, err_d;

  assign pat     = {hex1, hex0};
  assign same    = (pat == sample_q);
  assign is_idle = (pat == Idle);
  // Fires only on the edge where the saturating count reaches STABLE_CYCLES.
  assign eval    = same && (cnt_q == CntMax - 1'b1);

  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    ones_ok  = 1'b1;
    ones_val = 4'd0;
    case (hex0)
      7'h40:   ones_val = 4'd0;
      7'h79:   ones_val = 4'd1;
      7'h24:   ones_val = 4'd2;
      7'h30:   ones_val = 4'd3;
      7'h19:   ones_val = 4'd4;
      7'h12:   ones_val = 4'd5;
      7'h02:   ones_val = 4'd6;
      7'h78:   ones_val = 4'd7;
      7'h00:   ones_val = 4'd8;
      7'h18:   ones_val = 4'd9;
      default: ones_ok  = 1'b0;
    endcase
    // Leading zero is blanked, so the '0' glyph is not a legal tens digit.
    tens_ok  = 1'b1;
    tens_val = 2'd0;
    case (hex1)
      7'h7f:   tens_val = 2'd0;
      7'h79:   tens_val = 2'd1;
      7'h24:   tens_val = 2'd2;
      7'h30:   tens_val = 2'd3;
      default: tens_ok  = 1'b0;
    endcase
  end

  assign sum     = 6'(tens_val) * 6'd10 + 6'(ones_val);
  assign legal   = ones_ok && tens_ok && (sum <= 6'd31);
  assign capture = eval && !is_idle && legal && !(last_vld_q && (last_q == sum[4:0]));
  assign illegal = eval && !is_idle && !legal;

  always_comb begin
    last_vld_d = last_vld_q;
    last_d     = last_q;
    value_d    = value_q;
    valid_d    = valid_q;
    err_d      = err_q;
    if (eval && is_idle) begin
      last_vld_d = 1'b0;
    end
    if (capture) begin
      last_vld_d = 1'b1;
      last_d     = sum[4:0];
      value_d    = sum[4:0];
      valid_d    = 1'b1;
    end else if (valid_q && value_ready) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_q   <= Idle;
      cnt_q      <= '0;
      last_vld_q <= 1'b0;
      last_q     <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sample_q   <= pat;
      cnt_q      <= cnt_d;
      last_vld_q <= last_vld_d;
      last_q     <= last_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign pattern_err = err_q;

`ifdef SEG_ERR_COUNT_EN
  logic [ERR_W-1:0] errc_q, errc_d;

  // An illegal evaluation on the clearing edge leaves a count of one.
  always_comb begin
    errc_d = errc_q;
    if (err_clr) begin
      errc_d = '0;
    end
    if (illegal) begin
      if (err_clr) begin
        errc_d = ERR_W'(1);
      end else if (!(&errc_q)) begin
        errc_d = errc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      errc_q <= '0;
    end else begin
      errc_q <= errc_d;
    end
  end

  assign err_count = errc_q;
`endif

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Self-checking bench for hex_segment_decoder: reference model plus directed scenarios.
// err_count checks are active when SEG_ERR_COUNT_EN is defined.
module tb_hex_segment_decoder;

  localparam int unsigned S     = 4;
  localparam int unsigned ERR_W = 8;
  localparam int          CMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [6:0]       hex1, hex0;
  logic [4:0]       value;
  logic             value_valid;
  logic             value_ready;
  logic             pattern_err;
  logic             err_clr;
`ifdef SEG_ERR_COUNT_EN
  logic [ERR_W-1:0] err_count;
`endif

  hex_segment_decoder #(
    .STABLE_CYCLES(S),
    .ERR_W        (ERR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hex1       (hex1),
    .hex0       (hex0),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .pattern_err(pattern_err),
    .err_clr    (err_clr)
`ifdef SEG_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph tables; index is the digit value.
  logic [6:0] ones_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
  logic [6:0] tens_pat [4]  = '{7'h7f, 7'h79, 7'h24, 7'h30};

  // Reference model state
  logic [13:0] prev;
  int          run;
  bit          have_last;
  int          last_v;
  int          m_value, m_cnt;
  bit          m_valid, m_err;

  initial begin
    m_value = 0; m_cnt = 0; m_valid = 0; m_err = 0;
    run = 1; prev = 14'h3fff; have_last = 0; last_v = 0;
  end

  always @(posedge clk) begin
    automatic logic [13:0] smp = {hex1, hex0};
    automatic int  t = -1, o = -1, v;
    automatic bit  fire, cap = 0, ill = 0, hs;
    if (!reset_n) begin
      prev = 14'h3fff; run = 1; have_last = 0;
      m_value = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (smp == prev) run++;
      else begin
        run  = 1;
        prev = smp;
      end
      fire = (run == S + 1);
      hs   = m_valid && value_ready;
      for (int i = 0; i < 4; i++) if (hex1 == tens_pat[i]) t = i;
      for (int i = 0; i < 10; i++) if (hex0 == ones_pat[i]) o = i;
      v = t * 10 + o;
      if (fire) begin
        if (smp == 14'h3fff) have_last = 0;
        else if (t >= 0 && o >= 0 && v <= 31) cap = !(have_last && last_v == v);
        else ill = 1;
      end
      if (cap) begin
        m_value = v; m_valid = 1; have_last = 1; last_v = v;
      end else if (hs) m_valid = 0;
      if (err_clr) begin
        m_err = 0; m_cnt = 0;
      end
      if (ill) begin
        m_err = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  end

  int seen[$];

  always @(negedge clk) begin
    chk("model_value", int'(value), m_value);
    chk("model_valid", int'(value_valid), int'(m_valid));
    chk("model_err", int'(pattern_err), int'(m_err));
`ifdef SEG_ERR_COUNT_EN
    chk("model_cnt", int'(err_count), m_cnt);
`endif
    if (value_valid) seen.push_back(int'(value));
  end

  task automatic setp(input logic [6:0] h1, input logic [6:0] h0);
    hex1 = h1;
    hex0 = h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; value_ready = 1'b0; err_clr = 1'b0;
    setp(7'h7f, 7'h7f);
    cyc(2);
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(value_valid), 0);
    chk("rst_err", int'(pattern_err), 0);
`ifdef SEG_ERR_COUNT_EN
    chk("rst_cnt", int'(err_count), 0);
`endif

    // Value 3, latency and hold
    reset_n = 1'b1;
    setp(7'h7f, 7'h30);
    cyc(4);
    chk("e3_valid", int'(value_valid), 0);
    cyc(1);
    chk("e4_valid", int'(value_valid), 1);
    chk("e4_value", int'(value), 3);
    cyc(3);
    chk("hold_valid", int'(value_valid), 1);
    value_ready = 1'b1;
    cyc(1);
    value_ready = 1'b0;
    chk("ack_valid", int'(value_valid), 0);

    // Back-to-back results with ready held high
    seen.delete();
    value_ready = 1'b1;
    setp(7'h79, 7'h12);
    cyc(6);
    setp(7'h30, 7'h79);
    cyc(6);
    chk("pair_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("pair_first", seen[0], 15);
      chk("pair_second", seen[1], 31);
    end

    // Illegal patterns
    setp(7'h30, 7'h24);
    cyc(6);
    setp(7'h40, 7'h79);
    cyc(6);
    chk("ill_err", int'(pattern_err), 1);
    chk("ill_valid", int'(value_valid), 0);
`ifdef SEG_ERR_COUNT_EN
    chk("ill_cnt", int'(err_count), 2);
`endif
    setp(7'h30, 7'h30);
    cyc(4);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_race_err", int'(pattern_err), 1);
`ifdef SEG_ERR_COUNT_EN
    chk("clr_race_cnt", int'(err_count), 1);
`endif
    cyc(2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_err", int'(pattern_err), 0);

    // Unstable runs and duplicate suppression
    seen.delete();
    setp(7'h7f, 7'h78);
    cyc(2);
    setp(7'h7f, 7'h18);
    cyc(2);
    setp(7'h7f, 7'h78);
    cyc(6);
    chk("glitch_count", seen.size(), 1);
    if (seen.size() == 1) chk("glitch_value", seen[0], 7);
    setp(7'h7f, 7'h18);
    cyc(1);
    setp(7'h7f, 7'h78);
    cyc(6);
    chk("dup_count", seen.size(), 1);

    // Latest-wins buffer
    value_ready = 1'b0;
    setp(7'h7f, 7'h12);
    cyc(6);
    setp(7'h79, 7'h24);
    cyc(6);
    chk("lw_value", int'(value), 12);
    chk("lw_valid", int'(value_valid), 1);
    setp(7'h24, 7'h40);
    cyc(4);
    value_ready = 1'b1;
    cyc(1);
    value_ready = 1'b0;
    chk("same_edge_value", int'(value), 20);
    chk("same_edge_valid", int'(value_valid), 1);

    // Reset mid-operation
    setp(7'h24, 7'h12);
    cyc(6);
    chk("pre_rst_value", int'(value), 25);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("mid_rst_value", int'(value), 0);
    chk("mid_rst_valid", int'(value_valid), 0);
    chk("mid_rst_err", int'(pattern_err), 0);
    cyc(4);
    chk("post_rst_e3_valid", int'(value_valid), 0);
    cyc(1);
    chk("post_rst_e4_valid", int'(value_valid), 1);
    chk("post_rst_e4_value", int'(value), 25);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
